// File: rtl/rheed_result_packer.sv
// rheed_result_packer
// Captures one bank of per-crop CNN results, prefixes a 64-bit frame header
// (magic, crop count, frame ID) and streams the zero-padded buffer out as a
// fixed-length AXI4-Stream burst with tlast on the final beat.
module rheed_result_packer #(
    parameter int          NUM_CROPS = 5,
    parameter int          CROP_BITS = 160,
    parameter int          OUT_WIDTH = 256,
    parameter logic [15:0] MAGIC     = 16'hB0E5
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 s_axis_tvalid,
    output logic                 s_axis_tready,
    input  logic [CROP_BITS-1:0] s_axis_tdata [NUM_CROPS],
    output logic                 m_axis_tvalid,
    input  logic                 m_axis_tready,
    output logic [OUT_WIDTH-1:0] m_axis_tdata,
    output logic                 m_axis_tlast,
    output logic [31:0]          frame_cnt,
    output logic                 busy
);

    localparam int NUM_BEATS = (64 + NUM_CROPS * CROP_BITS + OUT_WIDTH - 1) / OUT_WIDTH;
    localparam int BUF_BITS  = NUM_BEATS * OUT_WIDTH;
    localparam int BEAT_W    = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NUM_BEATS - 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t                state_r;
    state_t                state_next_s;
    logic [BUF_BITS-1:0]   buf_r;
    logic [BUF_BITS-1:0]   cap_vec_s;
    logic [BEAT_W-1:0]     beat_cnt_r;
    logic [31:0]           cap_cnt_r;
    logic [31:0]           frame_cnt_r;
    logic                  tready_r;
    logic                  cap_hs_s;
    logic                  beat_hs_s;
    logic                  last_s;
    logic                  m_tvalid_s;
    logic                  m_tlast_s;
    logic [OUT_WIDTH-1:0]  m_tdata_s;

    assign cap_hs_s  = s_axis_tvalid & tready_r & (state_r == IDLE);
    assign beat_hs_s = (state_r == SEND) & m_axis_tready;
    assign last_s    = (beat_cnt_r == LAST_BEAT);

    // Assemble the flat frame image (header + crops + zero padding) from the live inputs.
    always_comb begin
        cap_vec_s        = '0;
        cap_vec_s[15:0]  = MAGIC;
        cap_vec_s[23:16] = 8'(NUM_CROPS);
        cap_vec_s[31:24] = 8'h00;
        cap_vec_s[63:32] = cap_cnt_r;
        for (int k = 0; k < NUM_CROPS; k++) begin
            cap_vec_s[64 + k * CROP_BITS +: CROP_BITS] = s_axis_tdata[k];
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state decode: capture moves to SEND, last-beat handshake returns to IDLE.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (cap_hs_s) begin
                    state_next_s = SEND;
                end else begin
                    state_next_s = IDLE;
                end
            end
            SEND: begin
                if (beat_hs_s && last_s) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = SEND;
                end
            end
            default: state_next_s = IDLE;
        endcase
    end

    // FSM output decode from registered state only; data is forced to zero outside SEND.
    always_comb begin
        m_tvalid_s = 1'b0;
        m_tlast_s  = 1'b0;
        m_tdata_s  = '0;
        case (state_r)
            SEND: begin
                m_tvalid_s = 1'b1;
                m_tlast_s  = last_s;
                m_tdata_s  = buf_r[int'(beat_cnt_r) * OUT_WIDTH +: OUT_WIDTH];
            end
            IDLE: begin
                m_tvalid_s = 1'b0;
                m_tlast_s  = 1'b0;
                m_tdata_s  = '0;
            end
            default: begin
                m_tvalid_s = 1'b0;
                m_tlast_s  = 1'b0;
                m_tdata_s  = '0;
            end
        endcase
    end

    // Datapath: frame buffer, beat/capture/frame counters and the registered input-ready.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            buf_r       <= '0;
            beat_cnt_r  <= '0;
            cap_cnt_r   <= 32'd0;
            frame_cnt_r <= 32'd0;
            tready_r    <= 1'b0;
        end else begin
            tready_r <= (state_next_s == IDLE);
            if (cap_hs_s) begin
                buf_r      <= cap_vec_s;
                beat_cnt_r <= '0;
                cap_cnt_r  <= cap_cnt_r + 32'd1;
            end else if (beat_hs_s) begin
                if (last_s) begin
                    frame_cnt_r <= frame_cnt_r + 32'd1;
                end else begin
                    beat_cnt_r <= beat_cnt_r + BEAT_W'(1);
                end
            end else begin
                beat_cnt_r <= beat_cnt_r;
            end
        end
    end

    assign s_axis_tready = tready_r;
    assign m_axis_tvalid = m_tvalid_s;
    assign m_axis_tlast  = m_tlast_s;
    assign m_axis_tdata  = m_tdata_s;
    assign frame_cnt     = frame_cnt_r;
    assign busy          = (state_r == SEND);

endmodule

// File: tb/tb_rheed_result_packer.sv
// Directed self-checking bench for rheed_result_packer (default build plus a
// NUM_CROPS=1 build). Inputs are driven and outputs sampled 1 ns after posedge.
module tb_rheed_result_packer;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         s_tvalid = 1'b0;
    logic         s_tready;
    logic [159:0] s_tdata [5];
    logic         m_tvalid;
    logic         m_tready = 1'b1;
    logic [255:0] m_tdata;
    logic         m_tlast;
    logic [31:0]  frame_cnt;
    logic         busy;

    logic         s1_tvalid = 1'b0;
    logic         s1_tready;
    logic [159:0] s1_tdata [1];
    logic         m1_tvalid;
    logic         m1_tready = 1'b1;
    logic [255:0] m1_tdata;
    logic         m1_tlast;
    logic [31:0]  frame_cnt1;
    logic         busy1;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int cap_cyc = 0;

    rheed_result_packer dut (
        .clk(clk), .reset_n(reset_n),
        .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready), .s_axis_tdata(s_tdata),
        .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready), .m_axis_tdata(m_tdata),
        .m_axis_tlast(m_tlast), .frame_cnt(frame_cnt), .busy(busy)
    );

    rheed_result_packer #(.NUM_CROPS(1)) dut1 (
        .clk(clk), .reset_n(reset_n),
        .s_axis_tvalid(s1_tvalid), .s_axis_tready(s1_tready), .s_axis_tdata(s1_tdata),
        .m_axis_tvalid(m1_tvalid), .m_axis_tready(m1_tready), .m_axis_tdata(m1_tdata),
        .m_axis_tlast(m1_tlast), .frame_cnt(frame_cnt1), .busy(busy1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Expected 4-beat frame image for the default build.
    function automatic logic [1023:0] exp_buf(input logic [31:0] id, input logic [7:0] base);
        logic [1023:0] v;
        v = '0;
        v[15:0]  = 16'hB0E5;
        v[23:16] = 8'd5;
        v[63:32] = id;
        for (int k = 0; k < 5; k++) v[64 + 160 * k +: 160] = {20{8'(base + 8'(k))}};
        return v;
    endfunction

    task automatic set_crops(input logic [7:0] base);
        for (int k = 0; k < 5; k++) s_tdata[k] = {20{8'(base + 8'(k))}};
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        s_tvalid = 1'b0;
        m_tready = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        @(posedge clk); #1;
    endtask

    // Capture one bank and follow its beats; returns early at beat stop_at (if >= 0).
    task automatic run_frame(input logic [31:0] id, input logic [7:0] base, input bit bp,
                             input bit keep_valid, input int stop_at);
        logic [1023:0] e;
        logic [3:0] pat;
        bit ok;
        int b;
        int n;
        pat = 4'b1001;
        e = exp_buf(id, base);
        set_crops(base);
        s_tvalid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (s_tready === 1'b1) ok = 1'b1;
            @(posedge clk); #1;
        end
        cap_cyc = cyc;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL capture_timeout id=%h got tready=%b want 1", id, s_tready);
        end
        if (!keep_valid) s_tvalid = 1'b0;
        b = 0;
        n = 0;
        while (b < 4 && n < 40) begin
            if (b == stop_at) return;
            m_tready = bp ? pat[n % 4] : 1'b1;
            checks++;
            if (m_tvalid !== 1'b1) begin
                errors++;
                $display("FAIL beat_valid id=%h beat=%0d got %b want 1", id, b, m_tvalid);
            end
            checks++;
            if (m_tdata !== e[256 * b +: 256]) begin
                errors++;
                $display("FAIL beat_data id=%h beat=%0d got %h want %h", id, b, m_tdata, e[256 * b +: 256]);
            end
            checks++;
            if (m_tlast !== (b == 3)) begin
                errors++;
                $display("FAIL beat_tlast id=%h beat=%0d got %b want %b", id, b, m_tlast, (b == 3));
            end
            checks++;
            if (s_tready !== 1'b0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL send_flags id=%h beat=%0d got tready=%b busy=%b want 0/1", id, b, s_tready, busy);
            end
            @(posedge clk); #1;
            if (m_tready) b++;
            n++;
        end
        m_tready = 1'b1;
        checks++;
        if (n >= 40) begin
            errors++;
            $display("FAIL beat_timeout id=%h got %0d beats want 4", id, b);
        end
        checks++;
        if (m_tvalid !== 1'b0 || s_tready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL post_frame id=%h got tvalid=%b tready=%b busy=%b want 0/1/0", id, m_tvalid, s_tready, busy);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (s_tready !== 1'b0 || m_tvalid !== 1'b0 || m_tlast !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags got tready=%b tvalid=%b tlast=%b busy=%b want 0", s_tready, m_tvalid, m_tlast, busy);
        end
        checks++;
        if (m_tdata !== 256'd0 || frame_cnt !== 32'd0) begin
            errors++;
            $display("FAIL reset_data got tdata=%h frame_cnt=%0d want 0", m_tdata, frame_cnt);
        end
        reset_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (s_tready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_tready got %b want 1", s_tready);
        end
    endtask

    task automatic test_basic();
        logic [1023:0] e;
        e = exp_buf(32'd0, 8'h10);
        set_crops(8'h10);
        s_tvalid = 1'b1;
        @(posedge clk); #1;
        s_tvalid = 1'b0;
        checks++;
        if (m_tvalid !== 1'b1 || m_tdata[63:0] !== 64'h0000_0000_0005_B0E5) begin
            errors++;
            $display("FAIL basic_header got valid=%b hdr=%h want 1/0000000000005b0e5", m_tvalid, m_tdata[63:0]);
        end
        for (int b = 0; b < 4; b++) begin
            checks++;
            if (m_tvalid !== 1'b1 || m_tdata !== e[256 * b +: 256] || m_tlast !== (b == 3)) begin
                errors++;
                $display("FAIL basic_beat%0d got v=%b last=%b data=%h want data=%h", b, m_tvalid, m_tlast, m_tdata, e[256 * b +: 256]);
            end
            if (b == 3) begin
                checks++;
                if (m_tdata[255:96] !== 160'd0) begin
                    errors++;
                    $display("FAIL basic_pad got %h want 0", m_tdata[255:96]);
                end
            end
            @(posedge clk); #1;
        end
        checks++;
        if (frame_cnt !== 32'd1 || m_tvalid !== 1'b0) begin
            errors++;
            $display("FAIL basic_frame_cnt got %0d valid=%b want 1/0", frame_cnt, m_tvalid);
        end
    endtask

    task automatic test_backpressure();
        run_frame(32'd1, 8'h50, 1'b1, 1'b0, -1);
        checks++;
        if (frame_cnt !== 32'd2) begin
            errors++;
            $display("FAIL bp_frame_cnt got %0d want 2", frame_cnt);
        end
    endtask

    task automatic test_back_to_back();
        int c0;
        int c1;
        do_reset();
        run_frame(32'd0, 8'h30, 1'b0, 1'b1, -1);
        c0 = cap_cyc;
        run_frame(32'd1, 8'h30, 1'b0, 1'b1, -1);
        c1 = cap_cyc;
        run_frame(32'd2, 8'h30, 1'b0, 1'b0, -1);
        checks++;
        if (c1 - c0 != 5 || cap_cyc - c1 != 5) begin
            errors++;
            $display("FAIL b2b_period got %0d,%0d cycles want 5,5", c1 - c0, cap_cyc - c1);
        end
        checks++;
        if (frame_cnt !== 32'd3) begin
            errors++;
            $display("FAIL b2b_frame_cnt got %0d want 3", frame_cnt);
        end
    endtask

    task automatic test_reset_mid_frame();
        run_frame(32'd3, 8'h60, 1'b0, 1'b0, -1);
        run_frame(32'd4, 8'h70, 1'b0, 1'b0, -1);
        run_frame(32'd5, 8'h80, 1'b0, 1'b0, 2);
        reset_n = 1'b0;
        #1;
        checks++;
        if (m_tvalid !== 1'b0 || busy !== 1'b0 || m_tlast !== 1'b0 || frame_cnt !== 32'd0) begin
            errors++;
            $display("FAIL midreset_async got tvalid=%b busy=%b tlast=%b frame_cnt=%0d want 0", m_tvalid, busy, m_tlast, frame_cnt);
        end
        @(posedge clk);
        #1 reset_n = 1'b1;
        @(posedge clk); #1;
        run_frame(32'd0, 8'h90, 1'b0, 1'b0, -1);
        checks++;
        if (frame_cnt !== 32'd1) begin
            errors++;
            $display("FAIL midreset_frame_cnt got %0d want 1", frame_cnt);
        end
    endtask

    task automatic test_wrap();
        force dut.cap_cnt_r = 32'hFFFF_FFFF;
        #1;
        release dut.cap_cnt_r;
        run_frame(32'hFFFF_FFFF, 8'hA0, 1'b0, 1'b0, -1);
        run_frame(32'h0000_0000, 8'hB0, 1'b0, 1'b0, -1);
        checks++;
        if (frame_cnt !== 32'd3) begin
            errors++;
            $display("FAIL wrap_frame_cnt got %0d want 3", frame_cnt);
        end
    endtask

    task automatic test_single_crop();
        logic [255:0] e1;
        s1_tdata[0] = {20{8'hA5}};
        e1 = {32'd0, {20{8'hA5}}, 64'h0000_0000_0001_B0E5};
        checks++;
        if (s1_tready !== 1'b1) begin
            errors++;
            $display("FAIL nc1_tready got %b want 1", s1_tready);
        end
        s1_tvalid = 1'b1;
        @(posedge clk); #1;
        s1_tvalid = 1'b0;
        checks++;
        if (m1_tvalid !== 1'b1 || m1_tlast !== 1'b1 || m1_tdata !== e1) begin
            errors++;
            $display("FAIL nc1_beat got v=%b last=%b data=%h want 1/1/%h", m1_tvalid, m1_tlast, m1_tdata, e1);
        end
        @(posedge clk); #1;
        checks++;
        if (m1_tvalid !== 1'b0 || frame_cnt1 !== 32'd1 || s1_tready !== 1'b1) begin
            errors++;
            $display("FAIL nc1_done got v=%b frame_cnt=%0d tready=%b want 0/1/1", m1_tvalid, frame_cnt1, s1_tready);
        end
    endtask

    initial begin
        set_crops(8'h00);
        s1_tdata[0] = '0;
        test_reset();
        test_basic();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_frame();
        test_wrap();
        test_single_crop();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rheed_result_packer.md
# rheed_result_packer

Packs the per-crop CNN results from the RHEED inference pipeline into a 256-bit AXI4-Stream for the CustomLogic host-memory write path. It captures the NUM_CROPS×160-bit result bank in one handshake, prepends a 64-bit frame header, and emits a fixed-length, zero-padded burst with `m_axis_tlast` on the final beat. It sits between the inference block's result output and the on-board memory/DMA stream.

## Interface

Parameters:
- NUM_CROPS, 5, number of 160-bit crop results per frame (1..255)
- CROP_BITS, 160, width of one crop result
- OUT_WIDTH, 256, output beat width
- MAGIC, 16'hB0E5, header magic word
- Derived NUM_BEATS = ceil((64 + NUM_CROPS·CROP_BITS) / OUT_WIDTH); 4 at defaults

Ports:
- clk  in  1  sole clock
- reset_n  in  1  asynchronous, active-low reset
- s_axis_tvalid  in  1  result bank valid; held by upstream until accepted
- s_axis_tready  out  1  packer can capture a bank
- s_axis_tdata  in  [CROP_BITS-1:0] ×NUM_CROPS  unpacked array of crop results, index = crop index
- m_axis_tvalid  out  1  output beat valid
- m_axis_tready  in  1  downstream accepts beat
- m_axis_tdata  out  OUT_WIDTH  output beat
- m_axis_tlast  out  1  final beat of frame
- frame_cnt  out  32  number of frames fully transmitted
- busy  out  1  high from capture until last-beat handshake

## Operation

- Buffer layout, flat vector of NUM_BEATS·256 bits, bit 0 first:
  - [15:0] MAGIC; [23:16] NUM_CROPS; [31:24] 8'h00; [63:32] frame ID
  - Crop k occupies [64+160k +: 160]; all bits above the last crop are 0.
- Beat b = buffer[256b +: 256]; beats go out in ascending order of b.
- Frame ID = internal capture counter value at capture. It starts at 0, increments by 1 per capture and wraps 2^32−1 → 0.
- FSM:
  - IDLE: s_axis_tready=1. On s_axis_tvalid&&s_axis_tready, latch all crops and the header into the buffer, clear the beat counter, increment the capture counter, and go to SEND.
  - SEND: m_axis_tvalid=1, m_axis_tdata=beat[beat_cnt], m_axis_tlast=(beat_cnt==NUM_BEATS−1).
    - On handshake with non-last beat: beat_cnt+1.
    - On handshake with last beat: frame_cnt+1, go to IDLE.
- s_axis_tready=0 throughout SEND. Upstream is held off, so no bank is lost and none is partially overwritten.
- m_axis_tdata, m_axis_tlast and buffer contents are stable while m_axis_tvalid=1 and m_axis_tready=0.
- busy = (state==SEND).

## Timing

- Reset (async assert, sync deassert in clk domain): state IDLE; s_axis_tready=0 while reset_n=0, then 1 from the first cycle after release.
  - m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, busy=0.
  - frame_cnt=0, capture counter=0, beat counter=0.
- Reset mid-frame: outputs drop immediately and the partial frame is abandoned with no tlast. The next accepted bank carries frame ID 0.
- Latency: a capture handshake at edge N gives m_axis_tvalid=1 with beat 0 after edge N.
- With m_axis_tready held at 1, beats occupy NUM_BEATS consecutive cycles.
- After the last-beat handshake, state is IDLE for one cycle with s_axis_tready=1. Minimum frame period is NUM_BEATS+1 cycles.
- frame_cnt updates on the edge of the last-beat handshake.
- All outputs are registered or decoded from registered state only. There is no combinational path from s_axis_* or m_axis_tready to any output.

## Test plan

- Reset, then one bank with crop k = {20{8'h10+k}}, m_axis_tready=1.
  - Required output: 4 beats on consecutive cycles.
  - Beat 0 [63:0] = 64'h0000_0000_0005_B0E5.
  - Crops appear at bit offsets 64, 224, 384, 544, 704; bits [1023:864] = 0.
  - tlast only on beat 3; frame_cnt=1.
- Backpressure: m_axis_tready toggles 1,0,0,1 per cycle.
  - Beat data and tlast are stable during stalls; all 4 beats arrive in order.
  - s_axis_tready=0 until one cycle after the last handshake.
- Back-to-back: 3 banks with s_axis_tvalid held high.
  - Header frame IDs are 0, 1, 2; each frame takes 5 cycles at full throughput; frame_cnt=3.
- Async reset asserted during beat 2 of frame 5.
  - m_axis_tvalid drops without waiting for a clock edge; frame_cnt=0.
  - The next frame carries ID 0 and transmits all 4 beats correctly.
- Wrap: force the capture counter to 32'hFFFF_FFFF and send 2 frames. Required header IDs are FFFF_FFFF then 0000_0000.
- NUM_CROPS=1 build: NUM_BEATS=1, a single beat with tlast=1, crop at [223:64], [255:224]=0.
